// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the parallel-to-serial feeder and its detector-side bench.
package par2ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Enable levels shared with the detector bench
  localparam logic EN_SHIFT = 1'b1;
  localparam logic EN_STALL = 1'b0;

  // Bit-counter width for a given word length (at least one bit)
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/par2ser_feeder.sv
// Parallel-to-serial bit source with a one-word holding buffer for gap-free streaming.
module par2ser_feeder
  import par2ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned     CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_n;
  logic [WIDTH-1:0]   sreg, sreg_n;
  logic [WIDTH-1:0]   hbuf, hbuf_n;
  logic               hvalid, hvalid_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               accept, load, shift, word_done;
  logic [WIDTH-1:0]   sreg_shifted;

  function automatic logic out_bit(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? s[WIDTH-1] : s[0];
  endfunction

  // Next-state computation; outputs are registered from these next values
  always_comb begin
    state_n      = state;
    sreg_n       = sreg;
    hbuf_n       = hbuf;
    hvalid_n     = hvalid;
    cnt_n        = cnt;
    sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    shift        = (state == SHIFT) && en;
    word_done    = shift && (cnt == LAST);
    // Buffer is drained whenever the shift register frees up, en or not in IDLE
    load         = hvalid && ((state == IDLE) || word_done);
    accept       = din_valid && !hvalid;

    if (accept) begin
      hbuf_n   = din;
      hvalid_n = 1'b1;
    end

    if (load) begin
      sreg_n   = hbuf;
      hvalid_n = 1'b0;
      cnt_n    = '0;
      state_n  = SHIFT;
    end else if (word_done) begin
      sreg_n  = sreg_shifted;
      cnt_n   = '0;
      state_n = IDLE;
    end else if (shift) begin
      sreg_n = sreg_shifted;
      cnt_n  = cnt + CNT_W'(1);
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sreg      <= '0;
      hbuf      <= '0;
      hvalid    <= 1'b0;
      cnt       <= '0;
      din_ready <= 1'b1;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      hbuf      <= hbuf_n;
      hvalid    <= hvalid_n;
      cnt       <= cnt_n;
      din_ready <= !hvalid_n;
      ser_valid <= (state_n == SHIFT);
      ser_out   <= (state_n == SHIFT) ? out_bit(sreg_n) : 1'b0;
      ser_last  <= (state_n == SHIFT) && (cnt_n == LAST);
      busy      <= (state_n == SHIFT) || hvalid_n;
    end
  end

endmodule

// File: tb/tb_par2ser_feeder.sv
// Bench for par2ser_feeder: MSB-first and LSB-first instances against a word/bit-index reference model.
module tb_par2ser_feeder;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         en;
  logic         din_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
  logic         din_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;

  int checks = 0;
  int errors = 0;

  // Reference model: word being serialized, bits still to show, holding word
  logic [W-1:0] m_word, h_word;
  int           m_left;
  bit           h_full;
  logic [W-1:0] wq[$];

  always #5 clk = ~clk;

  par2ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready_m),
    .en(en), .ser_out(ser_out_m), .ser_valid(ser_valid_m), .ser_last(ser_last_m), .busy(busy_m)
  );

  par2ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
    .en(en), .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_last(ser_last_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_bit(input bit msb);
    int k;
    if (m_left == 0) return 1'b0;
    k = W - m_left;
    return msb ? m_word[W-1-k] : m_word[k];
  endfunction

  task automatic model_clear();
    m_left = 0;
    h_full = 1'b0;
    m_word = '0;
    h_word = '0;
  endtask

  // One clock edge of the reference model, using the inputs present before the edge
  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic e);
    bit acc;
    acc = v && !h_full;
    if (m_left > 0 && e) m_left--;
    if (m_left == 0 && h_full) begin
      m_word = h_word;
      m_left = W;
      h_full = 1'b0;
    end else if (acc) begin
      h_word = d;
      h_full = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("ser_valid_msb", 32'(ser_valid_m), 32'(m_left > 0));
    check("ser_out_msb",   32'(ser_out_m),   32'(exp_bit(1'b1)));
    check("ser_last_msb",  32'(ser_last_m),  32'(m_left == 1));
    check("busy_msb",      32'(busy_m),      32'((m_left > 0) || h_full));
    check("din_ready_msb", 32'(din_ready_m), 32'(!h_full));
    check("ser_valid_lsb", 32'(ser_valid_l), 32'(m_left > 0));
    check("ser_out_lsb",   32'(ser_out_l),   32'(exp_bit(1'b0)));
    check("ser_last_lsb",  32'(ser_last_l),  32'(m_left == 1));
    check("busy_lsb",      32'(busy_l),      32'((m_left > 0) || h_full));
    check("din_ready_lsb", 32'(din_ready_l), 32'(!h_full));
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic e);
    din_valid = v;
    din       = d;
    en        = e;
    @(posedge clk);
    model_edge(v, d, e);
    #1;
    compare_all();
  endtask

  // Present queued words with din_valid held while any remain
  task automatic run_stream(input int n, input logic e);
    for (int i = 0; i < n; i++) begin
      logic         v;
      logic [W-1:0] d;
      bit           acc;
      v   = (wq.size() > 0);
      d   = v ? wq[0] : W'(0);
      acc = v && !h_full;
      cycle(v, d, e);
      if (acc) void'(wq.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_msb"}, 32'(ser_valid_m), 32'(0));
    check({tag, "_out_msb"},   32'(ser_out_m),   32'(0));
    check({tag, "_last_msb"},  32'(ser_last_m),  32'(0));
    check({tag, "_busy_msb"},  32'(busy_m),      32'(0));
    check({tag, "_valid_lsb"}, 32'(ser_valid_l), 32'(0));
    check({tag, "_busy_lsb"},  32'(busy_l),      32'(0));
  endtask

  initial begin
    reset     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    en        = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;

    // Single word 0xAA
    wq.push_back(8'hAA);
    run_stream(12, 1'b1);

    // Back-to-back 0xF0, 0x55 with valid held
    wq.push_back(8'hF0);
    wq.push_back(8'h55);
    run_stream(22, 1'b1);

    // 0xA5 with a three-cycle stall while bit 3 is showing
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0);
    repeat (9) cycle(1'b0, '0, 1'b1);

    // 0x01: LSB instance shows 1 then seven 0s
    cycle(1'b1, 8'h01, 1'b1);
    repeat (10) cycle(1'b0, '0, 1'b1);

    // Reset at bit 5 with a second word buffered
    wq.push_back(8'hC3);
    wq.push_back(8'h3C);
    run_stream(7, 1'b1);
    check("buffered_before_reset", 32'(busy_m && !din_ready_m), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    wq.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (12) cycle(1'b0, '0, 1'b1);

    // Randomized traffic and stalls
    for (int i = 0; i < 600; i++) begin
      logic         v, e;
      logic [W-1:0] d;
      v = ($urandom_range(0, 9) < 6);
      e = ($urandom_range(0, 9) < 7);
      d = W'($urandom);
      cycle(v, d, e);
    end
    repeat (30) cycle(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
